// File: rtl/ivector_pkg.sv
// Shared definitions for the vector echo request driver and its expectation table.
// No logic; constants, FSM state encoding and a width helper only.
// No flow control of its own.
package ivector_pkg;

    localparam int NUM_METH_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A single-method configuration still needs a one-bit index.
    function automatic int meth_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int METH_W_DEF = meth_width(NUM_METH_DEF);

endpackage

// File: rtl/ivector_expect_table.sv
// Per-method next-expected value table: bulk load from seed, bump one entry by NUM_METH.
// Writes take effect next cycle; read is combinational.
// No backpressure; the driver qualifies load and increment strobes.
module ivector_expect_table
    import ivector_pkg::*;
#(
    parameter int NUM_METH = NUM_METH_DEF,
    parameter int DW       = 32,
    parameter int MW       = meth_width(NUM_METH)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          load_ena,
    input  logic [DW-1:0] load_seed,
    input  logic          inc_ena,
    input  logic [MW-1:0] inc_idx,
    input  logic [MW-1:0] rd_idx,
    output logic [DW-1:0] rd_v
);

    logic [DW-1:0] tbl_q [NUM_METH];

    always_ff @(posedge CLK) begin
        for (int m = 0; m < NUM_METH; m++) begin
            if (!nRST) begin
                tbl_q[m] <= '0;
            end else if (load_ena) begin
                tbl_q[m] <= load_seed + DW'(m);
            end else if (inc_ena && inc_idx == MW'(m)) begin
                tbl_q[m] <= tbl_q[m] + DW'(NUM_METH);
            end
        end
    end

    // Index values past NUM_METH-1 read as zero; the driver flags those separately.
    always_comb begin
        rd_v = '0;
        for (int m = 0; m < NUM_METH; m++) begin
            if (rd_idx == MW'(m)) rd_v = tbl_q[m];
        end
    end

endmodule

// File: rtl/ivector_driver.sv
// Issues a run of say(meth, v) requests round-robin over NUM_METH methods and checks heard() echoes.
// First request one cycle after start; done one cycle after the last accepted response.
// say__ENA waits on say__RDY and the outstanding limit; heard__RDY high in RUN/DRAIN; done waits on done__RDY.
module ivector_driver
    import ivector_pkg::*;
#(
    parameter int NUM_METH        = NUM_METH_DEF,
    parameter int MAX_OUTSTANDING = 16,
    parameter int DW              = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          start__ENA,
    input  logic [DW-1:0] start_count,
    input  logic [DW-1:0] start_seed,
    output logic          start__RDY,
    output logic          say__ENA,
    output logic [DW-1:0] say_meth,
    output logic [DW-1:0] say_v,
    input  logic          say__RDY,
    input  logic          heard__ENA,
    input  logic [DW-1:0] heard_meth,
    input  logic [DW-1:0] heard_v,
    output logic          heard__RDY,
    output logic          done__ENA,
    output logic [DW-1:0] done_errors,
    output logic [DW-1:0] done_received,
    input  logic          done__RDY
);

    localparam int MW = meth_width(NUM_METH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    state_t        state_q, state_d;
    logic [DW-1:0] count_q, issued_q, received_q, errors_q, say_v_q;
    logic [MW-1:0] meth_q;
    logic [OW-1:0] outstanding_q;

    logic          start_fire, heard_fire, meth_ok;
    logic [DW-1:0] issued_nxt, received_nxt, expect_v;

    assign start_fire   = start__ENA & start__RDY;
    assign heard_fire   = heard__ENA & heard__RDY;
    assign meth_ok      = heard_meth < DW'(NUM_METH);
    assign issued_nxt   = issued_q + DW'(say__ENA);
    assign received_nxt = received_q + DW'(heard_fire);

    ivector_expect_table #(
        .NUM_METH (NUM_METH),
        .DW       (DW),
        .MW       (MW)
    ) u_expect (
        .CLK       (CLK),
        .nRST      (nRST),
        .load_ena  (start_fire),
        .load_seed (start_seed),
        .inc_ena   (heard_fire & meth_ok),
        .inc_idx   (heard_meth[MW-1:0]),
        .rd_idx    (heard_meth[MW-1:0]),
        .rd_v      (expect_v)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // RUN can skip DRAIN when the final issue and final response land together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_fire) state_d = (start_count == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (issued_nxt == count_q)
                          state_d = (received_nxt == count_q) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (received_nxt == count_q) state_d = ST_DONE;
            ST_DONE:  if (done__ENA) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start__RDY = (state_q == ST_IDLE);
        heard__RDY = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done__ENA  = (state_q == ST_DONE) && done__RDY;
        say__ENA   = (state_q == ST_RUN) && say__RDY && (issued_q < count_q)
                     && (outstanding_q < OW'(MAX_OUTSTANDING));
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q       <= '0;
            issued_q      <= '0;
            received_q    <= '0;
            errors_q      <= '0;
            outstanding_q <= '0;
            say_v_q       <= '0;
            meth_q        <= '0;
        end else if (start_fire) begin
            count_q       <= start_count;
            issued_q      <= '0;
            received_q    <= '0;
            errors_q      <= '0;
            outstanding_q <= '0;
            say_v_q       <= start_seed;
            meth_q        <= '0;
        end else begin
            issued_q   <= issued_nxt;
            received_q <= received_nxt;
            if (say__ENA) begin
                say_v_q <= say_v_q + DW'(1);
                meth_q  <= (meth_q == MW'(NUM_METH - 1)) ? '0 : meth_q + MW'(1);
            end
            if (heard_fire && (!meth_ok || heard_v != expect_v)) errors_q <= errors_q + DW'(1);
            case ({say__ENA, heard_fire})
                2'b10:   outstanding_q <= outstanding_q + OW'(1);
                2'b01:   outstanding_q <= outstanding_q - OW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign say_meth      = DW'(meth_q);
    assign say_v         = say_v_q;
    assign done_errors   = errors_q;
    assign done_received = received_q;

endmodule
